paint_scheduler: RTL and testbench

Shares the single 64x24 box painter (`render_box20`) among three draw requesters: the board-clear sweep, the active-piece erase/draw sequencer, and the row-redraw engine. It sits between those requesters and the painter's start/busy/done handshake. Cell coordinates are accepted into a small command FIFO, converted to pixel origins, and issued to the painter one box at a time, so no requester has to poll `busy` itself.

---
 rtl/paint_scheduler.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_paint_scheduler.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/paint_scheduler.sv
// ---------------------------------------------------------------------------
// paint_scheduler
//
// Shares the single 64x24 box painter among three draw requesters: the
// board-clear sweep (0), the active-piece sequencer (1) and the row-redraw
// engine (2). A requester supplies a cell coordinate and a color. One winner
// per cycle is accepted into a small command FIFO, with the cell converted to
// a pixel origin on the way in. Commands are then issued to the painter one
// box at a time through its start/busy/done handshake, so no requester has to
// watch the painter itself.
//
// Configuration macro:
//   PAINT_SCHED_RR_EN  defined   -> round-robin arbitration among requesters
//                      undefined -> fixed priority req[0] > req[1] > req[2]
//
// Parameters:
//   FIFO_DEPTH  command FIFO entries (power of two, 2..16)
//
// Ports:
//   CLOCK_50   in   1   system clock
//   resetn     in   1   asynchronous active-low reset (shared with painter)
//   req        in   3   per-requester request level
//   req_x      in  12   cell x, 4 bits per requester (valid 0..9)
//   req_y      in  15   cell y, 5 bits per requester (valid 0..19)
//   req_color  in  27   3:3:3 RGB, 9 bits per requester
//   gnt        out  3   one-hot accept pulse, high the cycle after sampling
//   flush      in   1   synchronous discard of all queued commands
//   start      out  1   one-cycle painter kick
//   x0         out 10   pixel x origin to painter
//   y0         out  9   pixel y origin to painter
//   color      out  9   box color to painter
//   busy       in   1   painter working
//   done       in   1   painter completion pulse
//   idle       out  1   FIFO empty, issue FSM idle and painter not busy
//   err        out  1   sticky flag: an out-of-range cell was granted
// ---------------------------------------------------------------------------
module paint_scheduler #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [2:0]  req,
  input  logic [11:0] req_x,
  input  logic [14:0] req_y,
  input  logic [26:0] req_color,
  output logic [2:0]  gnt,
  input  logic        flush,
  output logic        start,
  output logic [9:0]  x0,
  output logic [8:0]  y0,
  output logic [8:0]  color,
  input  logic        busy,
  input  logic        done,
  output logic        idle,
  output logic        err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;

  logic [9:0] fifoX_q [FIFO_DEPTH];
  logic [8:0] fifoY_q [FIFO_DEPTH];
  logic [8:0] fifoC_q [FIFO_DEPTH];

  logic [2:0] gnt_q, gnt_d;
  logic [9:0] x0_q, x0_d;
  logic [8:0] y0_q, y0_d;
  logic [8:0] color_q, color_d;
  logic       err_q, err_d;

  logic [1:0] win;
  logic       winValid;
  logic [3:0] selX;
  logic [4:0] selY;
  logic [8:0] selC;
  logic [9:0] pxD;
  logic [8:0] pyD;
  logic       inRange;
  logic       accept;
  logic       push;
  logic       pop;

  assign winValid = |req;

  // -------------------------------------------------------------------------
  // Arbitration: choose one requester among those asserting req.
  // -------------------------------------------------------------------------
`ifdef PAINT_SCHED_RR_EN
  // lastGnt_q remembers the most recent winner; the search begins with the
  // requester after it, wrapping 2 -> 0. It resets to 2 so requester 0 leads.
  logic [1:0] lastGnt_q;

  always_comb begin
    win = 2'd0;
    case (lastGnt_q)
      2'd0: begin
        if (req[1])      win = 2'd1;
        else if (req[2]) win = 2'd2;
        else             win = 2'd0;
      end
      2'd1: begin
        if (req[2])      win = 2'd2;
        else if (req[0]) win = 2'd0;
        else             win = 2'd1;
      end
      default: begin
        if (req[0])      win = 2'd0;
        else if (req[1]) win = 2'd1;
        else             win = 2'd2;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      lastGnt_q <= 2'd2;
    end else if (accept) begin
      lastGnt_q <= win;
    end
  end
`else
  always_comb begin
    win = 2'd0;
    if (req[0])      win = 2'd0;
    else if (req[1]) win = 2'd1;
    else             win = 2'd2;
  end
`endif

  // Pick out the winner's fields from the packed request buses.
  always_comb begin
    selX = req_x[3:0];
    selY = req_y[4:0];
    selC = req_color[8:0];
    case (win)
      2'd1: begin
        selX = req_x[7:4];
        selY = req_y[9:5];
        selC = req_color[17:9];
      end
      2'd2: begin
        selX = req_x[11:8];
        selY = req_y[14:10];
        selC = req_color[26:18];
      end
      default: begin
        selX = req_x[3:0];
        selY = req_y[4:0];
        selC = req_color[8:0];
      end
    endcase
  end

  // Cell to pixel: x*64 is a plain shift, y*24 is y*16 + y*8.
  assign pxD = {selX, 6'b000000};
  assign pyD = {selY, 4'b0000} + {1'b0, selY, 3'b000};

  assign inRange = (selX <= 4'd9) && (selY <= 5'd19);

  // The fullness test uses the registered count, so a pop on the same edge
  // does not make room for a push until the following cycle.
  assign accept = !flush && (count_q < DEPTH_C) && winValid;

  // Out-of-range winners are still granted but never reach the painter.
  assign push = accept && inRange;

  // Flush takes precedence over a pending issue: the head is discarded along
  // with the rest of the queue rather than being sent to the painter.
  assign pop = (state_q == IDLE) && (count_q != '0) && !busy && !flush;

  // -------------------------------------------------------------------------
  // FIFO bookkeeping.
  // -------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (flush) begin
      count_d = '0;
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      fifoX_q[wrPtr_q] <= pxD;
      fifoY_q[wrPtr_q] <= pyD;
      fifoC_q[wrPtr_q] <= selC;
    end
  end

  // -------------------------------------------------------------------------
  // Issue FSM and painter-facing output registers. The box parameters are
  // captured at the pop and stay put until the next pop.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    color_d = color_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = ISSUE;
          x0_d    = fifoX_q[rdPtr_q];
          y0_d    = fifoY_q[rdPtr_q];
          color_d = fifoC_q[rdPtr_q];
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d = 3'b000;
    err_d = err_q;
    if (accept) begin
      gnt_d = 3'b001 << win;
      if (!inRange) err_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      count_q <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      gnt_q   <= 3'b000;
      x0_q    <= '0;
      y0_q    <= '0;
      color_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      gnt_q   <= gnt_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      color_q <= color_d;
      err_q   <= err_d;
    end
  end

  assign gnt   = gnt_q;
  assign start = (state_q == ISSUE);
  assign x0    = x0_q;
  assign y0    = y0_q;
  assign color = color_q;
  assign err   = err_q;
  assign idle  = (count_q == '0) && (state_q == IDLE) && !busy;

endmodule

// File: tb/tb_paint_scheduler.sv
// ---------------------------------------------------------------------------
// tb_paint_scheduler
//
// Drives paint_scheduler with directed scenarios and a randomized stretch,
// comparing every cycle against a queue-based reference model of the
// scheduler plus a simple painter that answers start with busy and done.
// ---------------------------------------------------------------------------
module tb_paint_scheduler;

  localparam int DEPTH = 4;

  logic        CLOCK_50 = 1'b0;
  logic        resetn;
  logic [2:0]  req;
  logic [11:0] req_x;
  logic [14:0] req_y;
  logic [26:0] req_color;
  logic [2:0]  gnt;
  logic        flush;
  logic        start;
  logic [9:0]  x0;
  logic [8:0]  y0;
  logic [8:0]  color;
  logic        busy;
  logic        done;
  logic        idle;
  logic        err;

  always #10 CLOCK_50 = ~CLOCK_50;

  paint_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .req      (req),
    .req_x    (req_x),
    .req_y    (req_y),
    .req_color(req_color),
    .gnt      (gnt),
    .flush    (flush),
    .start    (start),
    .x0       (x0),
    .y0       (y0),
    .color    (color),
    .busy     (busy),
    .done     (done),
    .idle     (idle),
    .err      (err)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of pending boxes, the phase of the box in
  // flight (0 idle, 1 kicking the painter, 2 waiting for done), and the
  // values the scheduler should currently present.
  typedef struct {
    int px;
    int py;
    int c;
  } cmd_t;

  cmd_t mq[$];
  int   mPhase;
  int   mX0;
  int   mY0;
  int   mColor;
  int   mGnt;
  int   mLast;
  bit   mErr;

  int fx[3];
  int fy[3];
  int fc[3];

  int pCnt;
  int pLen;
  bit randBusy;
  bit holdBusy;
  int startSeen;
  int gntSeen;

  int g0;
  int g1;
  int g2;

  // Single comparison point for everything the bench checks.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compareModel();
    checkOutput("gnt",   32'(gnt),   32'(mGnt));
    checkOutput("start", 32'(start), 32'(mPhase == 1));
    checkOutput("x0",    32'(x0),    32'(mX0));
    checkOutput("y0",    32'(y0),    32'(mY0));
    checkOutput("color", 32'(color), 32'(mColor));
    checkOutput("err",   32'(err),   32'(mErr));
    checkOutput("idle",  32'(idle),  32'(mq.size() == 0 && mPhase == 0 && !busy));
  endtask

  function automatic int pickWinner(input logic [2:0] r);
`ifdef PAINT_SCHED_RR_EN
    for (int k = 1; k <= 3; k++) begin
      if (r[(mLast + k) % 3]) return (mLast + k) % 3;
    end
`else
    for (int i = 0; i < 3; i++) begin
      if (r[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic modelReset();
    mq.delete();
    mPhase = 0;
    mX0    = 0;
    mY0    = 0;
    mColor = 0;
    mGnt   = 0;
    mErr   = 1'b0;
    mLast  = 2;
    pCnt   = -1;
    busy   = 1'b0;
    done   = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic modelEdge();
    int   sz;
    int   w;
    bit   acc;
    bit   pop;
    int   nextGnt;
    cmd_t head;
    sz  = mq.size();
    w   = pickWinner(req);
    acc = !flush && (sz < DEPTH) && (w >= 0);
    pop = (mPhase == 0) && (sz > 0) && !busy && !flush;
    nextGnt = 0;
    if (pop) begin
      head   = mq.pop_front();
      mX0    = head.px;
      mY0    = head.py;
      mColor = head.c;
    end
    if (acc) begin
      nextGnt = 1 << w;
      mLast   = w;
      if (fx[w] <= 9 && fy[w] <= 19) mq.push_back('{fx[w] * 64, fy[w] * 24, fc[w]});
      else mErr = 1'b1;
    end
    if (flush) mq.delete();
    if (mPhase == 0 && pop)       mPhase = 1;
    else if (mPhase == 1)         mPhase = 2;
    else if (mPhase == 2 && done) mPhase = 0;
    mGnt = nextGnt;
  endtask

  // Painter: sees start, stays busy for a while, then pulses done.
  task automatic drivePainter();
    if (mPhase == 1) begin
      pCnt = (pLen > 0) ? pLen : int'($urandom_range(1, 5));
      busy = 1'b0;
      done = 1'b0;
    end else if (pCnt > 0) begin
      busy = 1'b1;
      done = 1'b0;
      pCnt--;
    end else if (pCnt == 0) begin
      busy = 1'b0;
      done = 1'b1;
      pCnt = -1;
    end else begin
      done = 1'b0;
      busy = holdBusy || (randBusy && $urandom_range(0, 7) == 0);
    end
  endtask

  // One clock cycle: check the present outputs, apply new inputs, step the
  // model over the coming edge and land on the next falling edge.
  task automatic applyStimulus(input logic [2:0] r, input logic f);
    compareModel();
    req       = r;
    flush     = f;
    req_x     = {4'(fx[2]), 4'(fx[1]), 4'(fx[0])};
    req_y     = {5'(fy[2]), 5'(fy[1]), 5'(fy[0])};
    req_color = {9'(fc[2]), 9'(fc[1]), 9'(fc[0])};
    drivePainter();
    modelEdge();
    @(negedge CLOCK_50);
    if (start) startSeen++;
    if (gnt != 3'b000) gntSeen++;
  endtask

  task automatic setAll(input int x, input int y, input int c);
    for (int i = 0; i < 3; i++) begin
      fx[i] = x;
      fy[i] = y;
      fc[i] = c;
    end
  endtask

  task automatic doReset();
    resetn    = 1'b0;
    req       = 3'b000;
    flush     = 1'b0;
    req_x     = '0;
    req_y     = '0;
    req_color = '0;
    holdBusy  = 1'b0;
    randBusy  = 1'b0;
    modelReset();
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pLen = 3;
    setAll(0, 0, 0);
    doReset();

    // Reset values.
    checkOutput("rst_gnt",   32'(gnt),   32'd0);
    checkOutput("rst_start", 32'(start), 32'd0);
    checkOutput("rst_x0",    32'(x0),    32'd0);
    checkOutput("rst_y0",    32'(y0),    32'd0);
    checkOutput("rst_color", 32'(color), 32'd0);
    checkOutput("rst_err",   32'(err),   32'd0);
    checkOutput("rst_idle",  32'(idle),  32'd1);

    // Single request from the piece sequencer.
    $display("[TB] single request");
    setAll(3, 5, 'h1C7);
    applyStimulus(3'b010, 1'b0);
    checkOutput("single_gnt",     32'(gnt),   32'b010);
    checkOutput("single_early",   32'(start), 32'd0);
    applyStimulus(3'b000, 1'b0);
    checkOutput("single_start",   32'(start), 32'd1);
    checkOutput("single_gnt_off", 32'(gnt),   32'd0);
    checkOutput("single_x0",      32'(x0),    32'd192);
    checkOutput("single_y0",      32'(y0),    32'd120);
    checkOutput("single_color",   32'(color), 32'h1C7);
    repeat (8) applyStimulus(3'b000, 1'b0);
    checkOutput("single_idle", 32'(idle), 32'd1);

    // Contention: all three held for three grants.
    $display("[TB] contention");
    doReset();
    setAll(2, 3, 'h055);
    applyStimulus(3'b111, 1'b0);
    g0 = int'(gnt);
    applyStimulus(3'b111, 1'b0);
    g1 = int'(gnt);
    applyStimulus(3'b111, 1'b0);
    g2 = int'(gnt);
`ifdef PAINT_SCHED_RR_EN
    checkOutput("cont_g0", 32'(g0), 32'b001);
    checkOutput("cont_g1", 32'(g1), 32'b010);
    checkOutput("cont_g2", 32'(g2), 32'b100);
`else
    checkOutput("cont_g0", 32'(g0), 32'b001);
    checkOutput("cont_g1", 32'(g1), 32'b001);
    checkOutput("cont_g2", 32'(g2), 32'b001);
`endif
    repeat (30) applyStimulus(3'b000, 1'b0);
    checkOutput("cont_idle", 32'(idle), 32'd1);

    // Full FIFO with the painter held busy.
    $display("[TB] full fifo");
    doReset();
    setAll(1, 2, 'h111);
    holdBusy = 1'b1;
    gntSeen  = 0;
    repeat (6) applyStimulus(3'b001, 1'b0);
    checkOutput("full_gnts", 32'(gntSeen), 32'd4);
    holdBusy = 1'b0;
    applyStimulus(3'b001, 1'b0);
    checkOutput("full_pop_start", 32'(start), 32'd1);
    checkOutput("full_pop_nognt", 32'(gnt),   32'd0);
    applyStimulus(3'b001, 1'b0);
    checkOutput("full_next_gnt", 32'(gnt), 32'b001);
    repeat (40) applyStimulus(3'b000, 1'b0);
    checkOutput("full_idle", 32'(idle), 32'd1);

    // Boundary cells.
    $display("[TB] boundary cells");
    doReset();
    setAll(9, 19, 'h0AA);
    applyStimulus(3'b001, 1'b0);
    applyStimulus(3'b000, 1'b0);
    checkOutput("bnd_start", 32'(start), 32'd1);
    checkOutput("bnd_x0",    32'(x0),    32'd576);
    checkOutput("bnd_y0",    32'(y0),    32'd456);
    repeat (8) applyStimulus(3'b000, 1'b0);
    checkOutput("bnd_err_clear", 32'(err), 32'd0);
    setAll(10, 0, 'h1FF);
    applyStimulus(3'b001, 1'b0);
    checkOutput("oor_gnt", 32'(gnt), 32'b001);
    startSeen = 0;
    repeat (5) applyStimulus(3'b000, 1'b0);
    checkOutput("oor_nostart", 32'(startSeen), 32'd0);
    checkOutput("oor_err",     32'(err),       32'd1);
    checkOutput("oor_idle",    32'(idle),      32'd1);

    // Flush with three queued and one box in flight.
    $display("[TB] flush");
    doReset();
    pLen = 8;
    setAll(1, 1, 'h0F0);
    applyStimulus(3'b001, 1'b0);
    applyStimulus(3'b000, 1'b0);
    repeat (3) applyStimulus(3'b010, 1'b0);
    applyStimulus(3'b000, 1'b1);
    checkOutput("flush_busy_box", 32'(idle), 32'd0);
    startSeen = 0;
    repeat (20) applyStimulus(3'b000, 1'b0);
    checkOutput("flush_nostart", 32'(startSeen), 32'd0);
    checkOutput("flush_idle",    32'(idle),      32'd1);

    // Reset while waiting on the painter with two commands queued.
    $display("[TB] reset mid-box");
    doReset();
    setAll(4, 4, 'h00F);
    applyStimulus(3'b001, 1'b0);
    applyStimulus(3'b000, 1'b0);
    applyStimulus(3'b010, 1'b0);
    applyStimulus(3'b100, 1'b0);
    applyStimulus(3'b000, 1'b0);
    #2;
    resetn = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    req    = 3'b000;
    #1;
    checkOutput("mid_rst_gnt",   32'(gnt),   32'd0);
    checkOutput("mid_rst_start", 32'(start), 32'd0);
    checkOutput("mid_rst_x0",    32'(x0),    32'd0);
    checkOutput("mid_rst_y0",    32'(y0),    32'd0);
    checkOutput("mid_rst_color", 32'(color), 32'd0);
    checkOutput("mid_rst_err",   32'(err),   32'd0);
    checkOutput("mid_rst_idle",  32'(idle),  32'd1);
    modelReset();
    @(negedge CLOCK_50);
    resetn    = 1'b1;
    startSeen = 0;
    repeat (10) applyStimulus(3'b000, 1'b0);
    checkOutput("post_rst_nostart", 32'(startSeen), 32'd0);

    // Randomized traffic against the model.
    $display("[TB] random traffic");
    doReset();
    pLen     = 0;
    randBusy = 1'b1;
    for (int n = 0; n < 800; n++) begin
      logic [2:0] r;
      logic       f;
      for (int i = 0; i < 3; i++) begin
        fx[i] = ($urandom_range(0, 40) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
        fy[i] = ($urandom_range(0, 40) == 0) ? int'($urandom_range(20, 31)) : int'($urandom_range(0, 19));
        fc[i] = int'($urandom_range(0, 511));
      end
      r = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) r = 3'b000;
      f = ($urandom_range(0, 40) == 0);
      applyStimulus(r, f);
    end
    randBusy = 1'b0;
    repeat (60) applyStimulus(3'b000, 1'b0);
    checkOutput("rand_drain_idle", 32'(idle), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
